instr_mem_prog: RTL
===================

Name: instr_mem_prog

Overview:
Parametrised, loadable instruction memory that replaces the fixed combinational instruction table in the fetch stage. It has a registered fetch port with a stall hold and a valid flag. A write-only program-load port with a valid/ready handshake lets the bench or a boot loader place programs at run time. After every reset, an internal clear engine fills the whole array with the filler instruction before fetch goes live.

Parameters:
DATA_W, 16, instruction width in bits
ADDR_W, 16, PC width in bits
DEPTH, 64, number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_W and need not be a power of two
FILL_INSTR, 16'hD001, filler/no-op word used for clear and for out-of-range fetch

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
PC  in  ADDR_W  fetch address
fetch_en  in  1  request a fetch this cycle
stall  in  1  hold the current INSTR and instr_valid
INSTR  out  DATA_W  fetched instruction (registered)
instr_valid  out  1  INSTR corresponds to an accepted fetch
load_valid  in  1  load beat offered
load_ready  out  1  load beat can be accepted
load_addr  in  ADDR_W  load word address
load_data  in  DATA_W  load word
lock  in  1  write-protect; blocks all loads
busy  out  1  clear engine is running
load_err  out  1  sticky flag: an out-of-range load was accepted and dropped

Behaviour:
- Reset (asynchronous assert):
  - INSTR = FILL_INSTR, instr_valid = 0, load_err = 0, busy = 1, load_ready = 0.
  - FSM enters CLEAR with clear_ptr = 0.
- FSM states and transitions:
  - CLEAR: write FILL_INSTR to mem[clear_ptr] and increment clear_ptr each cycle. Takes exactly DEPTH cycles. After writing DEPTH-1, go to RUN.
  - RUN: normal operation. Stays in RUN until rst.
  - rst asserted in any state, including mid-CLEAR, restarts CLEAR from clear_ptr = 0.
- In CLEAR:
  - fetch_en is ignored; instr_valid = 0; INSTR = FILL_INSTR.
  - load_ready = 0; no load beat is accepted.
- Fetch in RUN, latency 1:
  - If stall = 1: INSTR and instr_valid hold their values, regardless of fetch_en.
  - Else if fetch_en = 1: on the next edge, INSTR = mem[PC] and instr_valid = 1.
  - Else: instr_valid = 0 on the next edge; INSTR holds.
  - If PC >= DEPTH: INSTR = FILL_INSTR and instr_valid = 1. No error is raised.
- Load in RUN:
  - load_ready = ~lock, combinationally, only in RUN.
  - A beat is accepted when load_valid && load_ready. The write takes effect at that edge.
  - If load_addr >= DEPTH: the write is dropped and load_err is set. load_err stays set until rst.
- Same-cycle fetch and load to the same in-range address: fetch returns the new load_data (write-first bypass).
- PC and load_addr are unsigned; there is no wrap-around. Upper bits beyond the implemented depth are compared against DEPTH, not truncated.
- DEPTH = 1: CLEAR lasts 1 cycle. Only PC = 0 is in range.
- busy = 1 exactly when in CLEAR.

Decomposition:
- Shared package/header: opcode constants (OP_ADDI = 4'h3, OP_LW = 4'h8, OP_SW = 4'hA, OP_BNE = 4'hE, OP_JMP = 4'hF), FILL_INSTR default, and the FSM state encodings CLEAR = 1'b0 and RUN = 1'b1.
- One sub-module: imem_array, a DEPTH x DATA_W synchronous-write, asynchronous-read storage array.
- The top level holds the FSM, clear counter, address-range checks, bypass mux and output registers.

Test Plan:
1. Reset release: rst high for 3 cycles, then low; DEPTH = 64. Required: busy = 1 for exactly 64 cycles, then 0. load_ready rises in the same cycle busy falls. Fetching PC = 0..63 returns 16'hD001 each time, with instr_valid = 1 one cycle after each fetch_en.
2. Load then fetch: load 16'h3011 @1, 16'hE011 @32, 16'hF001 @33. Fetch PC = 1, 32, 33. Required: INSTR = 3011, E011, F001, each one cycle after its request.
3. Stall hold: fetch PC = 1 to get INSTR = 3011, then assert stall for 4 cycles while PC = 32 and fetch_en = 1. Required: INSTR = 3011 and instr_valid = 1 throughout. One cycle after stall drops, INSTR = E011.
4. Lock and range:
   - With lock = 1 and load_valid = 1: load_ready = 0 and memory is unchanged.
   - With lock = 0, load to addr 64 (DEPTH = 64): the beat is accepted, load_err = 1, and a fetch of PC = 64 returns D001.
5. Bypass: in one cycle, fetch_en = 1 and load_valid = 1 with PC = load_addr = 5, load_data = 16'hA0F0. Required: INSTR = A0F0 next cycle, and a later fetch of PC = 5 also returns A0F0.
6. Reset mid-clear: assert rst at cycle 20 of CLEAR. Required: after release, busy is high for a full 64 cycles again. Words previously loaded at 1 and 33 read D001. load_err = 0.

Source files
------------

// File: rtl/instr_mem_prog_pkg.sv
// Shared constants for the loadable fetch-stage instruction memory.
package instr_mem_prog_pkg;

  // Opcode field values (instr[15:12]) used by programs placed in the array
  localparam logic [3:0] OP_ADDI = 4'h3;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'hA;
  localparam logic [3:0] OP_BNE  = 4'hE;
  localparam logic [3:0] OP_JMP  = 4'hF;

  // Filler / no-op word written by the clear engine and returned out of range
  localparam logic [15:0] FILL_INSTR_DEF = 16'hD001;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } imem_state_t;

endpackage

// File: rtl/instr_mem_prog_imem_array.sv
// DEPTH x DATA_W storage: synchronous write, asynchronous read.
module imem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Single write port; the caller guarantees waddr < DEPTH
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_mem_prog.sv
// Loadable instruction memory: clear-after-reset engine, registered fetch
// port with stall hold, and a write-only program-load port.
module instr_mem_prog
  import instr_mem_prog_pkg::*;
#(
  parameter int                 DATA_W     = 16,
  parameter int                 ADDR_W     = 16,
  parameter int                 DEPTH      = 64,
  parameter logic [DATA_W-1:0]  FILL_INSTR = DATA_W'(FILL_INSTR_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PC,
  input  logic              fetch_en,
  input  logic              stall,
  output logic [DATA_W-1:0] INSTR,
  output logic              instr_valid,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              lock,
  output logic              busy,
  output logic              load_err
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  LAST    = IDX_W'(DEPTH - 1);
  // One extra bit so DEPTH == 2**ADDR_W is still representable
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

  imem_state_t       state, state_nxt;
  logic [IDX_W-1:0]  clear_ptr;
  logic              pc_ok, ld_ok, load_fire, bypass;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  // Full-width compares: out-of-range upper bits must never alias low words
  assign pc_ok     = {1'b0, PC} < DEPTH_L;
  assign ld_ok     = {1'b0, load_addr} < DEPTH_L;
  assign load_fire = load_valid && (state == RUN) && !lock;
  assign bypass    = load_fire && ld_ok && (load_addr == PC);

  imem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (PC[IDX_W-1:0]),
    .rdata (mem_rdata)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CLEAR;
    else     state <= state_nxt;
  end

  // Next state: CLEAR walks every word once, then RUN until reset
  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clear_ptr == LAST) state_nxt = RUN;
  end

  // FSM outputs: status flags and the shared array write port
  always_comb begin
    busy       = 1'b0;
    load_ready = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = clear_ptr;
    mem_wdata  = FILL_INSTR;
    case (state)
      CLEAR: begin
        busy   = 1'b1;
        mem_we = 1'b1;
      end
      RUN: begin
        load_ready = !lock;
        if (load_fire && ld_ok) begin
          mem_we    = 1'b1;
          mem_waddr = load_addr[IDX_W-1:0];
          mem_wdata = load_data;
        end
      end
      default: ;
    endcase
  end

  // Clear pointer restarts from zero on every reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  clear_ptr <= '0;
    else if (state == CLEAR)  clear_ptr <= clear_ptr + IDX_W'(1);
  end

  // Fetch output registers: stall holds, write-first bypass, filler out of range
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      INSTR       <= FILL_INSTR;
      instr_valid <= 1'b0;
    end else if (state == CLEAR) begin
      INSTR       <= FILL_INSTR;
      instr_valid <= 1'b0;
    end else if (!stall) begin
      if (fetch_en) begin
        instr_valid <= 1'b1;
        if (!pc_ok)      INSTR <= FILL_INSTR;
        else if (bypass) INSTR <= load_data;
        else             INSTR <= mem_rdata;
      end else begin
        instr_valid <= 1'b0;
      end
    end
  end

  // Sticky flag for accepted-but-dropped out-of-range loads
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    load_err <= 1'b0;
    else if (load_fire && !ld_ok) load_err <= 1'b1;
  end

endmodule
